// File: rtl/instr_mem_pkg.sv
// Shared parameters and loader state type for the instruction memory loader.
package instr_mem_pkg;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned MEM_BYTES = 1 << ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_WR_B0,
    ST_WR_B1,
    ST_WR_B2,
    ST_WR_B3,
    ST_DONE
  } ldr_state_e;

endpackage

// File: rtl/instr_byte_ram.sv
// Byte-wide instruction RAM: one synchronous byte write port and one
// combinational little-endian 32-bit read port that wraps at the top of memory.
module instr_byte_ram
  import instr_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = instr_mem_pkg::ADDR_W,
  parameter int unsigned MEM_BYTES = instr_mem_pkg::MEM_BYTES
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [7:0] mem_q [MEM_BYTES];

  // Byte write; contents are deliberately not touched by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Unaligned little-endian fetch; lane addresses wrap modulo the memory size.
  always_comb begin
    rdata = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      rdata[8*k +: 8] = mem_q[raddr + ADDR_W'(k)];
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: accepts 32-bit words and writes them one byte
// per cycle into the byte RAM starting at a word-aligned base address.
module instr_mem_loader #(
  parameter int unsigned ADDR_W    = instr_mem_pkg::ADDR_W,
  parameter int unsigned MEM_BYTES = instr_mem_pkg::MEM_BYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              wr_valid,
  input  logic [31:0]       wr_data,
  input  logic              wr_last,
  output logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-2:0] word_count,
  output logic              overflow,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_instr
);

  import instr_mem_pkg::*;

  ldr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-3:0] wcnt_q, wcnt_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       data_q, data_d;
  logic              last_q, last_d;

  logic              byte_we;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] byte_addr;
  logic [7:0]        byte_data;
  logic [ADDR_W:0]   ptr_sum;

  assign ptr_sum    = {1'b0, ptr_q} + (ADDR_W+1)'(4);
  assign byte_addr  = ptr_q + ADDR_W'(lane);
  assign byte_data  = data_q[{lane, 3'b000} +: 8];
  assign busy       = (state_q != ST_IDLE);
  assign word_count = {1'b0, wcnt_q};
  assign overflow   = ovf_q;

  // State and session registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      wcnt_q  <= '0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wcnt_q  <= wcnt_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    wcnt_d   = wcnt_q;
    ovf_d    = ovf_q;
    data_d   = data_q;
    last_d   = last_q;
    wr_ready = 1'b0;
    done     = 1'b0;
    byte_we  = 1'b0;
    lane     = 2'd0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCEPT;
          ptr_d   = {base_addr[ADDR_W-1:2], 2'b00};
          wcnt_d  = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_ACCEPT: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          data_d  = wr_data;
          last_d  = wr_last;
          state_d = ST_WR_B0;
        end
      end
      ST_WR_B0: begin
        byte_we = 1'b1;
        lane    = 2'd0;
        state_d = ST_WR_B1;
      end
      ST_WR_B1: begin
        byte_we = 1'b1;
        lane    = 2'd1;
        state_d = ST_WR_B2;
      end
      ST_WR_B2: begin
        byte_we = 1'b1;
        lane    = 2'd2;
        state_d = ST_WR_B3;
      end
      ST_WR_B3: begin
        byte_we = 1'b1;
        lane    = 2'd3;
        ptr_d   = ptr_sum[ADDR_W-1:0];
        wcnt_d  = wcnt_q + 1'b1;
        if (ptr_sum >= (ADDR_W+1)'(MEM_BYTES)) begin
          ovf_d = 1'b1;
        end
        state_d = last_q ? ST_DONE : ST_ACCEPT;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset suppresses the byte write of the cycle it aborts, so an interrupted
  // word leaves its remaining bytes untouched.
  instr_byte_ram #(
    .ADDR_W   (ADDR_W),
    .MEM_BYTES(MEM_BYTES)
  ) u_ram (
    .clk  (clk),
    .we   (byte_we && rst_n),
    .waddr(byte_addr),
    .wdata(byte_data),
    .raddr(rd_addr),
    .rdata(rd_instr)
  );

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter ADDR_W, default 10, byte-address width of instruction memory.
REQ-002 Parameter MEM_BYTES, default 1024, memory depth in bytes (2**ADDR_W).
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 start  input  1  begin load session at base_addr; sampled only in IDLE.
REQ-007 base_addr  input  ADDR_W  session start byte address; bits [1:0] ignored (forced word-aligned).
REQ-008 wr_valid  input  1  wr_data holds a word to load.
REQ-009 wr_data  input  32  instruction word, stored little-endian.
REQ-010 wr_last  input  1  qualifies the accepted word as the session's final word.
REQ-011 wr_ready  output  1  loader can accept a word this cycle.
REQ-012 busy  output  1  session active (any state other than IDLE).
REQ-013 done  output  1  one-cycle pulse when the last word is fully written.
REQ-014 word_count  output  ADDR_W-1  words fully written this session.
REQ-015 overflow  output  1  sticky; write pointer wrapped past MEM_BYTES-1 this session.
REQ-016 rd_addr  input  ADDR_W  fetch-side byte address.
REQ-017 rd_instr  output  32  {mem[a+3],mem[a+2],mem[a+1],mem[a]}, a=rd_addr, offsets modulo MEM_BYTES.

Function
REQ-018 FSM states: IDLE, ACCEPT, WR_B0, WR_B1, WR_B2, WR_B3, DONE.
REQ-019 IDLE: start=1 -> ACCEPT; ptr <= {base_addr[ADDR_W-1:2],2'b00}; word_count <= 0; overflow <= 0.
REQ-020 start in any state other than IDLE SHALL be ignored.
REQ-021 wr_ready SHALL be 1 only in ACCEPT; a word is accepted when wr_valid && wr_ready.
REQ-022 On accept: latch wr_data and wr_last, go to WR_B0; no accept -> remain in ACCEPT.
REQ-023 WR_Bk (k=0..3): write byte wr_data[8k+7:8k] to mem[(ptr+k) mod MEM_BYTES] in that cycle; advance to next state.
REQ-024 Leaving WR_B3: ptr <= (ptr+4) mod MEM_BYTES; word_count increments; next state DONE if latched last else ACCEPT.
REQ-025 If ptr+4 reaches/exceeds MEM_BYTES, overflow SHALL set and hold until next session start or reset.
REQ-026 DONE: done=1 for exactly that cycle; next state IDLE.
REQ-027 Throughput: one word per 5 cycles with wr_valid held high; done asserts 5 cycles after the last accept edge.
REQ-028 word_count saturates at no value: it wraps modulo 2**(ADDR_W-2) alongside overflow.
REQ-029 rd_instr SHALL be combinational from rd_addr and array contents; a byte written in cycle N is visible after the edge ending cycle N.
REQ-030 Unaligned rd_addr SHALL be honoured byte-exactly (no alignment forced on the read port).

Reset
REQ-031 rst_n=0 at a clock edge: state IDLE, wr_ready 0, busy 0, done 0, word_count 0, overflow 0, ptr 0.
REQ-032 Reset mid-session SHALL abort immediately; bytes already written remain; unwritten bytes unchanged.
REQ-033 The memory array SHALL NOT be cleared by reset.

Structure
REQ-034 Shared package instr_mem_pkg SHALL hold ADDR_W, MEM_BYTES and the loader state enum type.
REQ-035 Sub-module instr_byte_ram: one synchronous byte write port, one combinational 4-byte little-endian read port.
REQ-036 FSM, pointer, counters reside in instr_mem_loader; estimated 150-250 lines total.

Verification
REQ-037 Start base 0x000, one word 0x8C220004 with last -> done pulse 5 cycles after accept; rd_addr 0x000 -> 0x8C220004; byte 0x000 = 0x04.
REQ-038 Base 0x010, three words back-to-back, wr_valid held -> wr_ready low 4 cycles between accepts; word_count=3; rd_addr 0x014 -> word 2; overflow=0.
REQ-039 Base 0x3FC, two words -> second word at 0x000..0x003; overflow=1; rd_addr 0x3FE -> {word2[15:0],word1[31:16]}.
REQ-040 Base 0x013 -> words written starting at 0x010.
REQ-041 rst_n low during WR_B2 -> next cycle busy=0, word_count=0; bytes 0-1 new, bytes 2-3 hold prior values.
REQ-042 start pulsed during WR_B1 -> ignored; ptr, word_count unaffected; session completes normally.
